// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// frame geometry, plus the half-bit offset used to qualify start bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT_DEF = 434;
    localparam int UART_DATA_BITS        = 8;

    // Offset from the start-bit edge to its centre, in clocks.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input. RST_VAL sets
// the value both flops take on reset so the output starts at the line's
// idle level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous input and let the first flop settle for a cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises the serial line, qualifies the start bit
// at its centre, samples eight data bits LSB-first at mid-bit and checks the
// stop bit, then emits a one-cycle byte-valid or framing-error strobe. A line
// held low after a bad stop bit parks the receiver in BREAK until it rises.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_Rx_Serial,
    output logic                      o_Rx_DV,
    output logic [UART_DATA_BITS-1:0] o_Rx_Byte,
    output logic                      o_Frame_Err,
    output logic                      o_Rx_Busy
);

    localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      w_s_rx;

    rx_state_t                 r_state,   w_state;
    logic [CNT_W-1:0]          r_clk_cnt, w_clk_cnt;
    logic [2:0]                r_bit_idx, w_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift,   w_shift;
    logic [UART_DATA_BITS-1:0] r_byte,    w_byte;
    logic                      r_dv,      w_dv;
    logic                      r_fe,      w_fe;

    // Line idles high, so the synchroniser resets high to avoid a false start.
    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_Rx_Serial),
        .o_sync  (w_s_rx)
    );

    // State, counters, shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_dv      <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_clk_cnt <= w_clk_cnt;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_byte    <= w_byte;
            r_dv      <= w_dv;
            r_fe      <= w_fe;
        end
    end

    // Next-state, bit timing and frame decisions, all taken on the synchronised line.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned and infers a latch.
        w_state   = r_state;
        w_clk_cnt = r_clk_cnt;
        w_bit_idx = r_bit_idx;
        w_shift   = r_shift;
        w_byte    = r_byte;
        w_dv      = 1'b0;
        w_fe      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_s_rx) begin
                    w_state   = START;
                    w_clk_cnt = '0;
                end
            end

            START: begin
                if (r_clk_cnt == HALF_CNT) begin
                    w_clk_cnt = '0;
                    w_bit_idx = '0;
                    // A line back high at mid-start-bit was only a glitch.
                    w_state   = w_s_rx ? IDLE : DATA;
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt          = '0;
                    w_shift[r_bit_idx] = w_s_rx;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state = STOP;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt = '0;
                    if (w_s_rx) begin
                        w_byte  = r_shift;
                        w_dv    = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_fe    = 1'b1;
                        w_state = BREAK;
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + CNT_W'(1);
                end
            end

            BREAK: begin
                if (w_s_rx) begin
                    w_state = IDLE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign o_Rx_DV     = r_dv;
    assign o_Rx_Byte   = r_byte;
    assign o_Frame_Err = r_fe;
    assign o_Rx_Busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: exact strobe timing, back-to-back frames,
// glitch rejection, framing error with held-low line, mid-frame reset, and a
// continuous stream at the minimum bit period on a second instance.
module tb_uart_rx_frame;

    localparam int CPB      = 434;
    localparam int CPB_FAST = 4;
    localparam int STOP_EDGE = 4 + (CPB - 1) / 2 + 9 * CPB;   // 4126

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_fast = 1'b1;

    logic       dv, fe, busy;
    logic [7:0] rx_byte;
    logic       f_dv, f_fe, f_busy;
    logic [7:0] f_byte;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_rx_frame #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_Rx_Serial (rx_line),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (rx_byte),
        .o_Frame_Err (fe),
        .o_Rx_Busy   (busy)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB_FAST)) u_dut_fast (
        .clk         (clk),
        .rst         (rst),
        .i_Rx_Serial (rx_fast),
        .o_Rx_DV     (f_dv),
        .o_Rx_Byte   (f_byte),
        .o_Frame_Err (f_fe),
        .o_Rx_Busy   (f_busy)
    );

    always #5 clk = ~clk;

    // Posedge counter: edge numbers in the timing checks are relative to this.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor for the main instance, sampled on the falling edge.
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         viol_cnt = 0;
    int         last_fe_cyc = 0;
    int         dv_cyc_q[$];
    logic [7:0] byte_q[$];
    logic       prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            if (dv) begin
                dv_cnt <= dv_cnt + 1;
                dv_cyc_q.push_back(cyc);
                byte_q.push_back(rx_byte);
            end
            if (fe) begin
                fe_cnt      <= fe_cnt + 1;
                last_fe_cyc <= cyc;
            end
            if ((dv && fe) || ((dv || fe) && prev_strobe))
                viol_cnt <= viol_cnt + 1;
            prev_strobe <= dv | fe;
        end
    end

    // Strobe monitor for the fast loopback instance.
    int f_dv_cnt = 0;
    int f_fe_cnt = 0;
    int f_bad_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (f_dv) begin
                f_dv_cnt <= f_dv_cnt + 1;
                if (f_byte !== 8'hA7) f_bad_cnt <= f_bad_cnt + 1;
            end
            if (f_fe) f_fe_cnt <= f_fe_cnt + 1;
        end
    end

    // Hard stop in case anything ever stalls the sequence.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Serialise one 8N1 frame LSB-first; called on a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb, input bit fast);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (fast) rx_fast = bits[i];
            else      rx_line = bits[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    int start_cyc;
    int n0;
    int dv0;
    int fe0;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dv",   {31'd0, dv},   32'd0);
        check("reset_fe",   {31'd0, fe},   32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_byte", {24'd0, rx_byte}, 32'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single frame 0xA7: strobe at edge 4126
        n0 = dv_cyc_q.size();
        start_cyc = cyc;
        send_frame(8'hA7, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        check("a7_dv_count", dv_cyc_q.size() - n0, 1);
        if (dv_cyc_q.size() > n0) begin
            check("a7_dv_edge", dv_cyc_q[n0] - start_cyc, STOP_EDGE);
            check("a7_byte",    {24'd0, byte_q[n0]}, 32'hA7);
        end
        check("a7_byte_held", {24'd0, rx_byte}, 32'hA7);
        check("a7_no_fe",     fe_cnt, 0);
        check("a7_idle",      {31'd0, busy}, 32'd0);

        // Back-to-back 0x00, 0xFF, 0x5A
        n0 = dv_cyc_q.size();
        start_cyc = cyc;
        send_frame(8'h00, 1'b1, CPB, 1'b0);
        send_frame(8'hFF, 1'b1, CPB, 1'b0);
        send_frame(8'h5A, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        check("b2b_dv_count", dv_cyc_q.size() - n0, 3);
        if (dv_cyc_q.size() >= n0 + 3) begin
            check("b2b_first_edge", dv_cyc_q[n0] - start_cyc, STOP_EDGE);
            check("b2b_gap1", dv_cyc_q[n0+1] - dv_cyc_q[n0],   10 * CPB);
            check("b2b_gap2", dv_cyc_q[n0+2] - dv_cyc_q[n0+1], 10 * CPB);
            check("b2b_byte0", {24'd0, byte_q[n0]},   32'h00);
            check("b2b_byte1", {24'd0, byte_q[n0+1]}, 32'hFF);
            check("b2b_byte2", {24'd0, byte_q[n0+2]}, 32'h5A);
        end
        check("b2b_no_fe", fe_cnt, 0);

        // Glitch of 100 cycles: rejected at the start-bit centre (edge 220)
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        start_cyc = cyc;
        rx_line = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        repeat (50) @(negedge clk);
        rx_line = 1'b1;
        repeat (119) @(negedge clk);
        check("glitch_busy_219", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("glitch_edge", cyc - start_cyc, 221);
        check("glitch_busy_221", {31'd0, busy}, 32'd0);
        check("glitch_no_dv", dv_cnt - dv0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        repeat (20) @(negedge clk);
        n0 = dv_cyc_q.size();
        send_frame(8'h3C, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        check("post_glitch_dv_count", dv_cyc_q.size() - n0, 1);
        check("post_glitch_byte", {24'd0, rx_byte}, 32'h3C);

        // 0x55 with stop low, line held low for 5 more bit times
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        start_cyc = cyc;
        send_frame(8'h55, 1'b0, CPB, 1'b0);
        check("fe_count", fe_cnt - fe0, 1);
        check("fe_edge", last_fe_cyc - start_cyc, STOP_EDGE);
        check("fe_no_dv", dv_cnt - dv0, 0);
        check("fe_byte_kept", {24'd0, rx_byte}, 32'h3C);
        repeat (5 * CPB) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_single_fe", fe_cnt - fe0, 1);
        check("break_no_dv", dv_cnt - dv0, 0);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        check("break_busy_rise2", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("break_exit", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("break_final_fe", fe_cnt - fe0, 1);
        check("break_final_dv", dv_cnt - dv0, 0);

        // Reset during data bit 4 of 0xC3 (bits 0..3 = 1,1,0,0); the
        // transmitter is reset too and returns the line to idle.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rx_line = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        repeat (200) @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dv",   {31'd0, dv},   32'd0);
        check("rst_fe",   {31'd0, fe},   32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_byte", {24'd0, rx_byte}, 32'h00);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check("rst_no_dv", dv_cnt - dv0, 0);
        check("rst_no_fe", fe_cnt - fe0, 0);
        n0 = dv_cyc_q.size();
        start_cyc = cyc;
        send_frame(8'h81, 1'b1, CPB, 1'b0);
        repeat (5) @(negedge clk);
        check("post_rst_dv_count", dv_cyc_q.size() - n0, 1);
        if (dv_cyc_q.size() > n0)
            check("post_rst_edge", dv_cyc_q[n0] - start_cyc, STOP_EDGE);
        check("post_rst_byte", {24'd0, rx_byte}, 32'h81);

        // Continuous 0xA7 stream at the minimum bit period
        for (int i = 0; i < 20; i++)
            send_frame(8'hA7, 1'b1, CPB_FAST, 1'b1);
        repeat (10) @(negedge clk);
        check("stream_dv_count", f_dv_cnt, 20);
        check("stream_bad_bytes", f_bad_cnt, 0);
        check("stream_no_fe", f_fe_cnt, 0);
        check("stream_byte", {24'd0, f_byte}, 32'hA7);

        check("strobe_exclusive", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

8N1 UART receiver that sits directly upstream of the command interpreter. It converts the asynchronous serial line into validated bytes. It synchronises the line, qualifies the start bit at half-bit, samples eight data bits LSB-first at mid-bit and checks the stop bit. It then emits either a one-cycle byte-valid strobe or a framing-error strobe. Its byte/strobe output is the input the command decoder consumes. Its bit timing matches the serialiser driven by `CLKS_PER_BIT`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (25 MHz / 57600 baud); must be ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_Rx_Serial`  in  1  asynchronous serial line, idle high.
- `o_Rx_DV`  out  1  one-cycle strobe; `o_Rx_Byte` is valid in the same cycle.
- `o_Rx_Byte`  out  8  last correctly framed byte; held until the next good frame.
- `o_Frame_Err`  out  1  one-cycle strobe when the stop bit samples low.
- `o_Rx_Busy`  out  1  high in every state except IDLE.

## Operation
- Input path: a 2-flop synchroniser (both flops reset to 1) produces `s_rx`. All decisions use `s_rx` only.
- Definitions: `H = (CLKS_PER_BIT-1)/2` (integer division); `clk_cnt` width = `$clog2(CLKS_PER_BIT)`; `bit_idx` is 3 bits.
- States:
  - IDLE: if `s_rx==0`, go to START with `clk_cnt=0`.
  - START: increment `clk_cnt`. When `clk_cnt==H`:
    - `s_rx==0`: go to DATA with `clk_cnt=0`, `bit_idx=0`.
    - `s_rx==1`: glitch; go to IDLE with no strobe.
  - DATA: when `clk_cnt==CLKS_PER_BIT-1`:
    - shift register bit `[bit_idx]` ← `s_rx`; `clk_cnt=0`.
    - if `bit_idx==7`, go to STOP; otherwise increment `bit_idx`.
  - STOP: when `clk_cnt==CLKS_PER_BIT-1`:
    - `s_rx==1`: `o_Rx_Byte` ← shift register, pulse `o_Rx_DV`, go to IDLE.
    - `s_rx==0`: pulse `o_Frame_Err`, leave `o_Rx_Byte` unchanged, go to BREAK.
  - BREAK: wait until `s_rx==1`, then go to IDLE. This prevents a held-low line from being read as a stream of 0x00 frames.
- `o_Rx_DV` and `o_Frame_Err` are mutually exclusive and never high for two consecutive cycles.
- Reset at any point, mid-frame included:
  - state → IDLE; counters → 0; synchroniser → 1.
  - all outputs → 0, including `o_Rx_Byte = 8'h00`.
  - the partial frame is discarded with no strobe.
- There is no flow control. The downstream block must consume the strobe in the cycle it is asserted.

## Timing
- Edge 1 is the clock edge at which the first synchroniser flop captures the start-bit low.
- START entered after edge 3.
- Start-bit check at edge `4+H`.
- Data bit n sampled at edge `4+H+(n+1)*CLKS_PER_BIT`.
- Stop bit checked at edge `4+H+9*CLKS_PER_BIT`. `o_Rx_DV`/`o_Frame_Err` are high for exactly the following cycle.
  - Default parameter: edge 4126.
- IDLE is re-entered at that same edge, so a start bit that begins immediately after the stop bit is accepted. Back-to-back frames need no idle gap beyond one stop bit.
- `o_Rx_Busy` rises the cycle after edge 3 and falls together with the strobe.
- Transmitter clock tolerance is ±(H / (9.5·CLKS_PER_BIT)), roughly ±5 %. Behaviour outside this range is undefined but must never lock up; BREAK always exits on line high.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t` {IDLE, START, DATA, STOP, BREAK};
  - localparam `UART_CLKS_PER_BIT_DEF = 434`;
  - localparam `UART_DATA_BITS = 8`.
- Sub-module `uart_sync2`: a 2-flop synchroniser with a reset-value parameter. It is reused by the other asynchronous inputs.
- The FSM, counters and shift register live in `uart_rx_frame`. Target size is roughly 150 RTL lines.

## Test plan
- Drive 0xA7 (LSB first, stop=1) at `CLKS_PER_BIT=434` → exactly one `o_Rx_DV` pulse at edge 4126, `o_Rx_Byte==8'hA7`, `o_Frame_Err` never high.
- Send 0x00, 0xFF and 0x5A back-to-back with no idle gap → three `o_Rx_DV` pulses spaced `10*CLKS_PER_BIT` cycles apart, bytes in order.
- Glitch the line low for 100 cycles (< H), then idle → no strobe, `o_Rx_Busy` returns to 0 by edge 221, and a following 0x3C frame is received correctly.
- Send 0x55 with the stop bit low, then hold low for 5 bit times → a single `o_Frame_Err` pulse, `o_Rx_Byte` keeps its previous value, `o_Rx_Busy` stays high until the line rises, and no 0x00 frames appear.
- Assert `rst` for 2 cycles during data bit 4 of 0xC3 → all outputs 0, no strobe for that frame, and the next 0x81 frame is received correctly.
- Loop back from the existing `uart_tx` (`CLKS_PER_BIT=434`, byte 0xA7, `i_Tx_DV` held high) → a continuous stream of `o_Rx_DV` with byte 0xA7 and no framing errors over 20 frames.
